// File: rtl/pe_data_feeder.sv
// Fetches the current channel's K*K weights and then its W*H pixels from one memory read port.
// Valid appears 2 cycles after each sampled request; no backpressure, since requests are the pacing.
module pe_data_feeder #(
  parameter int KERNEL_SIZE = 3,
  parameter int IFM_WIDTH   = 64,
  parameter int IFM_HEIGHT  = 64,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CHANNEL = 3,
  parameter int ADDR_WIDTH  = 16,
  parameter int WGT_BASE    = 0,
  parameter int IFM_BASE    = 1024
) (
  input  logic                  clk1,
  input  logic                  rst,
  input  logic                  start_conv,
  input  logic                  wgt_read,
  input  logic                  ifm_read,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] wgt_data,
  output logic                  wgt_valid,
  output logic                  wgt_last,
  output logic [DATA_WIDTH-1:0] ifm_data,
  output logic                  ifm_valid,
  output logic                  ifm_last,
  output logic                  end_channel,
  output logic                  end_all,
  output logic [4:0]            channel_num,
  output logic                  busy,
  output logic                  err_conflict
);
  localparam int KK     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NPIX   = IFM_WIDTH * IFM_HEIGHT;
  localparam int WIDX_W = $clog2(KK + 1);
  localparam int PIX_W  = $clog2(NPIX + 1);
  localparam logic [ADDR_WIDTH-1:0] WGT_BASE_A = ADDR_WIDTH'(WGT_BASE);
  localparam logic [ADDR_WIDTH-1:0] IFM_BASE_A = ADDR_WIDTH'(IFM_BASE);
  localparam logic [ADDR_WIDTH-1:0] KK_A       = ADDR_WIDTH'(KK);
  localparam logic [ADDR_WIDTH-1:0] NPIX_A     = ADDR_WIDTH'(NPIX);

  typedef enum logic [1:0] {S_IDLE, S_WGT, S_IFM} state_t;

  state_t                r_state, w_state_nxt;
  logic [WIDX_W-1:0]     r_widx, w_widx_nxt;
  logic [PIX_W-1:0]      r_pix, w_pix_nxt;
  logic [4:0]            r_chan, w_chan_inc, w_chan_cur;
  logic                  r_rd_en, r_rd_wgt, r_rd_last;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wgt_vld, r_wgt_last, r_ifm_vld, r_ifm_last, r_end_all, r_err;
  logic                  w_issue, w_issue_wgt, w_issue_last, w_conflict, w_last_rsp;
  logic [ADDR_WIDTH-1:0] w_wgt_addr, w_ifm_addr, w_issue_addr;

  assign w_last_rsp = r_rd_en & ~r_rd_wgt & r_rd_last;
  assign w_chan_inc = (r_chan == 5'(NUM_CHANNEL - 1)) ? 5'd0 : r_chan + 5'd1;
  // The channel only advances with the final pixel's valid, but a weight burst
  // requested in that same cycle must already address the next channel.
  assign w_chan_cur = w_last_rsp ? w_chan_inc : r_chan;
  assign w_wgt_addr = WGT_BASE_A + ADDR_WIDTH'(w_chan_cur) * KK_A + ADDR_WIDTH'(r_widx);
  assign w_ifm_addr = IFM_BASE_A + ADDR_WIDTH'(w_chan_cur) * NPIX_A + ADDR_WIDTH'(r_pix);
  assign w_issue_addr = w_issue_wgt ? w_wgt_addr : w_ifm_addr;

  always_comb begin
    w_state_nxt  = r_state;
    w_widx_nxt   = r_widx;
    w_pix_nxt    = r_pix;
    w_issue      = 1'b0;
    w_issue_wgt  = 1'b0;
    w_issue_last = 1'b0;
    w_conflict   = 1'b0;
    if (start_conv) begin
      w_state_nxt = S_IDLE;
      w_widx_nxt  = '0;
      w_pix_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: w_conflict = ifm_read;
        S_WGT:  w_conflict = wgt_read | ifm_read;
        S_IFM:  w_conflict = wgt_read;
        default: w_conflict = 1'b0;
      endcase
      if ((r_state == S_IDLE && wgt_read) || r_state == S_WGT) begin
        w_issue      = 1'b1;
        w_issue_wgt  = 1'b1;
        w_issue_last = (r_widx == WIDX_W'(KK - 1));
        w_widx_nxt   = r_widx + WIDX_W'(1);
        w_state_nxt  = S_WGT;
        if (w_issue_last) begin
          w_state_nxt = S_IFM;
          w_widx_nxt  = '0;
          w_pix_nxt   = '0;
        end
      end else if (r_state == S_IFM && ifm_read) begin
        w_issue      = 1'b1;
        w_issue_last = (r_pix == PIX_W'(NPIX - 1));
        w_pix_nxt    = r_pix + PIX_W'(1);
        if (w_issue_last) w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_widx     <= '0;
      r_pix      <= '0;
      r_chan     <= '0;
      r_rd_en    <= 1'b0;
      r_rd_wgt   <= 1'b0;
      r_rd_last  <= 1'b0;
      r_addr     <= '0;
      r_wgt_vld  <= 1'b0;
      r_wgt_last <= 1'b0;
      r_ifm_vld  <= 1'b0;
      r_ifm_last <= 1'b0;
      r_end_all  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_widx    <= w_widx_nxt;
      r_pix     <= w_pix_nxt;
      r_err     <= r_err | w_conflict;
      r_rd_en   <= w_issue;
      r_rd_wgt  <= w_issue_wgt;
      r_rd_last <= w_issue_last;
      if (w_issue) r_addr <= w_issue_addr;
      // An abort kills the response of the read currently on the memory port.
      if (start_conv) begin
        r_wgt_vld  <= 1'b0;
        r_wgt_last <= 1'b0;
        r_ifm_vld  <= 1'b0;
        r_ifm_last <= 1'b0;
        r_end_all  <= 1'b0;
        r_chan     <= '0;
      end else begin
        r_wgt_vld  <= r_rd_en & r_rd_wgt;
        r_wgt_last <= r_rd_en & r_rd_wgt & r_rd_last;
        r_ifm_vld  <= r_rd_en & ~r_rd_wgt;
        r_ifm_last <= w_last_rsp;
        r_end_all  <= w_last_rsp & (r_chan == 5'(NUM_CHANNEL - 1));
        if (w_last_rsp) r_chan <= w_chan_inc;
      end
    end
  end

  assign mem_rd_en    = r_rd_en;
  assign mem_addr     = r_addr;
  assign wgt_valid    = r_wgt_vld;
  assign wgt_last     = r_wgt_last;
  assign wgt_data     = r_wgt_vld ? mem_rd_data : '0;
  assign ifm_valid    = r_ifm_vld;
  assign ifm_last     = r_ifm_last;
  assign ifm_data     = r_ifm_vld ? mem_rd_data : '0;
  assign end_channel  = r_ifm_last;
  assign end_all      = r_end_all;
  assign channel_num  = r_chan;
  assign busy         = (r_state != S_IDLE);
  assign err_conflict = r_err;
endmodule
